// File: rtl/aes_inv_cipher_pkg.sv
// rtl/aes_inv_cipher_pkg.sv - shared types, constants, inverse S-box and GF(2^8) helpers
package aes_inv_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_e;

    localparam logic [3:0] NR      = 4'd10;
    localparam int         BLOCK_W = 128;

    // Index 0 is the leftmost byte, so the hex rows read exactly like the FIPS-197 table.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - request, round-key lookup and result signals of the inverse cipher
interface aes_inv_cipher_if;
    import aes_inv_cipher_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] ct_in;
    logic [3:0]         rk_idx;
    logic [BLOCK_W-1:0] rk_in;
    logic               busy;
    logic               done;
    logic [BLOCK_W-1:0] pt_out;

    modport master (
        output start, ct_in, rk_in,
        input  rk_idx, busy, done, pt_out
    );

    modport slave (
        input  start, ct_in, rk_in,
        output rk_idx, busy, done, pt_out
    );
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational inverse round; last_i skips InvMixColumns
module aes_inv_round
    import aes_inv_cipher_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rk_i,
    input  logic               last_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [7:0] ak [16];
    logic [7:0] mc [16];

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    function automatic int isr_src(input int i);
        return ((((i / 4) - (i % 4) + 4) % 4) * 4) + (i % 4);
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ak[i] = inv_sbox(state_i[127 - 8*isr_src(i) -: 8]) ^ rk_i[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = mul_0e(ak[4*c]) ^ mul_0b(ak[4*c+1]) ^ mul_0d(ak[4*c+2]) ^ mul_09(ak[4*c+3]);
            mc[4*c+1] = mul_09(ak[4*c]) ^ mul_0e(ak[4*c+1]) ^ mul_0b(ak[4*c+2]) ^ mul_0d(ak[4*c+3]);
            mc[4*c+2] = mul_0d(ak[4*c]) ^ mul_09(ak[4*c+1]) ^ mul_0e(ak[4*c+2]) ^ mul_0b(ak[4*c+3]);
            mc[4*c+3] = mul_0b(ak[4*c]) ^ mul_0d(ak[4*c+1]) ^ mul_09(ak[4*c+2]) ^ mul_0e(ak[4*c+3]);
        end
    end

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            state_o[127 - 8*i -: 8] = last_i ? ak[i] : mc[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES-128 decryption, one round per clock
module aes_inv_cipher
    import aes_inv_cipher_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    aes_inv_cipher_if.slave    bus
);

    state_e             fsm_q, fsm_d;
    logic [3:0]         rnd_q, rnd_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic               done_q, done_d;
    logic [3:0]         rk_idx_c;
    logic [BLOCK_W-1:0] round_out;

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (bus.rk_in),
        .last_i  (fsm_q == FINAL),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d    = fsm_q;
        rnd_d    = rnd_q;
        state_d  = state_q;
        pt_d     = pt_q;
        done_d   = 1'b0;
        rk_idx_c = NR;
        unique case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.ct_in ^ bus.rk_in;
                    rnd_d   = NR - 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx_c = rnd_q;
                state_d  = round_out;
                rnd_d    = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                rk_idx_c = 4'd0;
                pt_d     = round_out;
                done_d   = 1'b1;
                fsm_d    = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign bus.rk_idx = rk_idx_c;
    assign bus.busy   = (fsm_q != IDLE);
    assign bus.done   = done_q;
    assign bus.pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - scoreboard bench with FIPS-197 vectors and a reference key schedule
module tb_aes_inv_cipher;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_sel = 1'b0;
    logic [127:0] rkeys [2][11];
    logic [127:0] last_pt = '0;
    exp_t         exp_q [$];
    int           cyc    = 0;
    int           n_vec  = 0;
    int           n_fail = 0;

    aes_inv_cipher_if bus ();

    aes_inv_cipher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rk_in = (bus.rk_idx <= 4'd10) ? rkeys[key_sel][bus.rk_idx] : '0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a = a_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its algebraic definition: GF inverse then affine map.
    function automatic logic [7:0] fsbox(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        if (x == 8'h00) v = 8'h00;
        else for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fsbox(t[31:24]), fsbox(t[23:16]), fsbox(t[15:8]), fsbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkeys[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: each run's rk_idx/busy/done/pt_out timeline follows from its accept edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            begin : mon
                logic       exp_done;
                logic       exp_busy;
                logic [3:0] exp_idx;
                int         d;
                exp_done = 1'b0;
                exp_busy = 1'b0;
                exp_idx  = 4'd10;
                if (!rst_n) last_pt = '0;
                if (exp_q.size() > 0) begin
                    d = cyc - exp_q[0].acc;
                    if (d >= 0 && d <= 8) begin
                        exp_idx  = 4'(9 - d);
                        exp_busy = 1'b1;
                    end else if (d == 9) begin
                        exp_idx  = 4'd0;
                        exp_busy = 1'b1;
                    end else if (d == 10) begin
                        exp_done = 1'b1;
                    end
                end
                check("rk_idx", 128'(bus.rk_idx), 128'(exp_idx));
                check("busy", 128'(bus.busy), 128'(exp_busy));
                check("done", 128'(bus.done), 128'(exp_done));
                if (exp_done) begin
                    check("pt_out", bus.pt_out, exp_q[0].pt);
                    last_pt = exp_q[0].pt;
                    void'(exp_q.pop_front());
                end else begin
                    check("pt_hold", bus.pt_out, last_pt);
                end
            end
        end
    end

    task automatic issue(input logic sel, input logic [127:0] ct, input logic [127:0] pt);
        key_sel   = sel;
        bus.ct_in = ct;
        bus.start = 1'b1;
        exp_q.push_back('{pt: pt, acc: cyc + 1});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic run_block(input logic sel, input logic [127:0] ct, input logic [127:0] pt);
        @(negedge clk);
        issue(sel, ct, pt);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        drain(20);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.ct_in = '0;
        expand(0, C1_KEY);
        expand(1, B_KEY);

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", 128'(bus.busy), 128'd0);
        check("reset_done", 128'(bus.done), 128'd0);
        check("reset_pt", bus.pt_out, 128'd0);
        check("reset_rk_idx", 128'(bus.rk_idx), 128'd10);
        @(negedge clk);
        rst_n = 1'b1;

        run_block(0, C1_CT, C1_PT);
        run_block(1, B_CT, B_PT);

        // Start pulse while busy plus a ct_in that changes every cycle.
        @(negedge clk);
        issue(0, C1_CT, C1_PT);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.start = (i == 5);
        end
        drain(20);
        repeat (12) @(negedge clk);

        // start held high across two blocks.
        @(negedge clk);
        issue(0, C1_CT, C1_PT);
        n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%0b after %0d cycles, required 1", bus.done, n);
        end
        issue(1, B_CT, B_PT);
        @(negedge clk);
        bus.start = 1'b0;
        drain(20);

        // Reset in the middle of a run.
        @(negedge clk);
        issue(0, C1_CT, C1_PT);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", 128'(bus.busy), 128'd0);
        check("midrst_done", 128'(bus.done), 128'd0);
        check("midrst_pt", bus.pt_out, 128'd0);
        check("midrst_rk_idx", 128'(bus.rk_idx), 128'd10);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_block(0, C1_CT, C1_PT);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

endmodule
